// File: rtl/seg_defs.sv
// Shared definitions for the binary-to-BCD converter and the seven-segment display path.
package seg_defs;

  localparam logic [1:0]  ST_IDLE  = 2'b00;
  localparam logic [1:0]  ST_SHIFT = 2'b01;
  localparam logic [1:0]  ST_DONE  = 2'b10;

  localparam int unsigned SEG_MAX_VAL = 9999;
  localparam logic [15:0] SEG_BCD_SAT = 16'h9999;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD nibble holding 5 or more.
module bcd_add3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  always_comb begin
    nib_o = nib_i;
    if (nib_i >= 4'd5) nib_o = nib_i + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, with saturation above MAX_VAL.
module bin_to_bcd_seq
  import seg_defs::*;
#(
  parameter int unsigned WIDTH   = 14,
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned MAX_VAL = SEG_MAX_VAL
) (
  input  logic                  clock_100Mhz,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int unsigned        BW    = 4 * DIGITS;
  localparam int unsigned        CW    = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]   MAX_W = WIDTH'(MAX_VAL);
  localparam logic [BW-1:0]      SAT   = {DIGITS{SEG_BCD_SAT[3:0]}};

  logic [1:0]       state_q,   state_d;
  logic [WIDTH-1:0] shreg_q,   shreg_d;
  logic [BW-1:0]    scratch_q, scratch_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic             pend_q,    pend_d;
  logic [BW-1:0]    bcd_q,     bcd_d;
  logic             ovf_q,     ovf_d;
  logic             done_q,    done_d;
  logic [BW-1:0]    adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_i (scratch_q[4*g +: 4]),
      .nib_o (adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // done_q is still high in the first IDLE cycle; a start there is dropped, not accepted late
        if (start && !done_q) begin
          shreg_d   = bin_in;
          scratch_d = '0;
          cnt_d     = CW'(WIDTH);
          pend_d    = (bin_in > MAX_W);
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {scratch_d, shreg_d} = {adj, shreg_q} << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        bcd_d   = pend_q ? SAT : scratch_q;
        ovf_d   = pend_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign busy     = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq: latency, values, saturation, ignored starts, reset abort.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] bin_in = '0;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        overflow;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(
    .WIDTH   (14),
    .DIGITS  (4),
    .MAX_VAL (9999)
  ) u_dut (
    .clock_100Mhz (clk),
    .reset        (rst_n),
    .start        (start),
    .bin_in       (bin_in),
    .busy         (busy),
    .done         (done),
    .bcd_out      (bcd_out),
    .overflow     (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int unsigned v);
    int unsigned s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic wait_idle();
    int unsigned n = 0;
    while ((busy || done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < 50), 32'd1);
  endtask

  // Start at a negedge, then count cycles until done; the expected latency is 15 negedges.
  task automatic convert(input string tag, input logic [13:0] v,
                         input logic [15:0] exp_bcd, input logic exp_ov);
    int unsigned n = 0;
    int unsigned nbusy = 0;
    logic [15:0] held;
    wait_idle();
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 14'($urandom_range(0, 16383));
    while (!done && n < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 32'd15);
    chk({tag, "_busy_cycles"}, nbusy, 32'd15);
    chk({tag, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ov));
    held = bcd_out;
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, 32'(bcd_out), 32'(held));
  endtask

  initial begin
    int unsigned ndone;
    logic [13:0] v;

    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    convert("zero",  14'd0,     16'h0000, 1'b0);
    convert("v1234", 14'd1234,  16'h1234, 1'b0);
    convert("v9999", 14'd9999,  16'h9999, 1'b0);
    convert("v10000", 14'd10000, 16'h9999, 1'b1);
    convert("v16383", 14'd16383, 16'h9999, 1'b1);
    convert("v0509", 14'd509,   16'h0509, 1'b0);

    // start while busy and start during the done cycle must both be dropped
    wait_idle();
    @(negedge clk);
    bin_in = 14'd42;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    ndone  = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) ndone++;
      if (k == 15) chk("ign_bcd42", 32'(bcd_out), 32'h0042);
      start  = (k == 2) || (k == 15);
      bin_in = start ? 14'd7 : 14'd42;
      @(negedge clk);
    end
    start = 1'b0;
    chk("ign_done_count", ndone, 32'd1);
    chk("ign_bcd_final", 32'(bcd_out), 32'h0042);
    chk("ign_idle", 32'(busy), 32'd0);

    // overflow left set so the reset clearing it is observable
    convert("pre_rst", 14'd12000, 16'h9999, 1'b1);
    @(negedge clk);
    bin_in = 14'd5678;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bcd", 32'(bcd_out), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 32'd0);
    convert("v5678", 14'd5678, 16'h5678, 1'b0);

    for (int i = 0; i < 24; i++) begin
      v = 14'($urandom_range(0, 16383));
      convert("sweep", v, ref_bcd(int'(v)), v > 14'd9999);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
